// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply/divide unit producing Hi/Lo for the multicycle datapath.
// Optional MDU_EARLY_EXIT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_n;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [W:0]      mag_a_q;
  logic [W:0]      mag_b_q;
  logic [W2-1:0]   mcand_q;
  logic [W2-1:0]   acc_q;

  // Operand capture: magnitudes for signed ops, raw values otherwise
  logic            signed_op;
  logic            sa;
  logic            sb;
  logic [W:0]      mag_a_c;
  logic [W:0]      mag_b_c;

  always_comb begin
    signed_op = ~op[0];
    sa        = signed_op & a[W-1];
    sb        = signed_op & b[W-1];
    mag_a_c   = sa ? {1'b0, W'(~a + W'(1))} : {1'b0, a};
    mag_b_c   = sb ? {1'b0, W'(~b + W'(1))} : {1'b0, b};
  end

  // One iteration step for both the shift-add multiply and the restoring divide
  logic [W2-1:0]   mult_acc_c;
  logic [W:0]      div_shift_c;
  logic            div_ge_c;
  logic [W-1:0]    div_rem_c;
  logic [W2-1:0]   div_acc_c;
  logic            last_c;
  logic            exit_c;

  always_comb begin
    mult_acc_c  = mag_b_q[0] ? (acc_q + mcand_q) : acc_q;
    div_shift_c = {acc_q[W2-1:W], acc_q[W-1]};
    div_ge_c    = (div_shift_c >= mag_b_q);
    div_rem_c   = div_ge_c ? W'(div_shift_c - mag_b_q) : div_shift_c[W-1:0];
    div_acc_c   = {div_rem_c, acc_q[W-2:0], div_ge_c};
    last_c      = (cnt_q == CW'(WIDTH - 1));
`ifdef MDU_EARLY_EXIT_EN
    // Multiplier bits still to be consumed after this step are all zero
    exit_c      = last_c | (~is_div_q & (mag_b_q[W:1] == '0));
`else
    exit_c      = last_c;
`endif
  end

  // Sign correction and divide-by-zero selection for the final write
  logic            neg_q_c;
  logic            dz_c;
  logic [W2-1:0]   prod_c;
  logic [W-1:0]    quo_c;
  logic [W-1:0]    rem_c;
  logic [W-1:0]    raw_a_c;
  logic [W-1:0]    fix_hi_c;
  logic [W-1:0]    fix_lo_c;

  always_comb begin
    neg_q_c  = sign_a_q ^ sign_b_q;
    dz_c     = is_div_q & (mag_b_q == '0);
    prod_c   = neg_q_c ? (W2'(0) - acc_q) : acc_q;
    quo_c    = neg_q_c ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
    rem_c    = sign_a_q ? (W'(0) - acc_q[W2-1:W]) : acc_q[W2-1:W];
    raw_a_c  = sign_a_q ? W'((W+1)'(0) - mag_a_q) : W'(mag_a_q);
    fix_hi_c = prod_c[W2-1:W];
    fix_lo_c = prod_c[W-1:0];
    if (is_div_q) begin
      if (dz_c) begin
        fix_hi_c = raw_a_c;
        fix_lo_c = '1;
      end else begin
        fix_hi_c = rem_c;
        fix_lo_c = quo_c;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (exit_c) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            sign_a_q <= sa;
            sign_b_q <= sb;
            mag_a_q  <= mag_a_c;
            mag_b_q  <= mag_b_c;
            mcand_q  <= W2'(mag_a_c);
            acc_q    <= op[1] ? {W'(0), mag_a_c[W-1:0]} : '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (is_div_q) begin
            acc_q <= div_acc_c;
          end else begin
            acc_q   <= mult_acc_c;
            mcand_q <= mcand_q << 1;
            mag_b_q <= mag_b_q >> 1;
          end
        end
        S_FIX: begin
          hi       <= fix_hi_c;
          lo       <= fix_lo_c;
          div_zero <= dz_c;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases, randomized ops against an arithmetic model,
// handshake and reset behaviour.
module tb_mdu_iter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int checks = 0;
  int errors = 0;
  int e;
  int bc;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Reference results from plain 64-bit / SV integer arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
    longint          sp;
    longint unsigned up;
    int              q;
    int              r;
    mdz = 1'b0;
    mh  = '0;
    ml  = '0;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {mh, ml} = sp;
      end
      2'b01: begin
        up = {32'b0, x} * {32'b0, y};
        {mh, ml} = up;
      end
      default: begin
        if (y == 32'd0) begin
          mdz = 1'b1;
          mh  = x;
          ml  = '1;
        end else if (o == 2'b11) begin
          ml = x / y;
          mh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          ml = x;
          mh = '0;
        end else begin
          q  = $signed(x) / $signed(y);
          r  = $signed(x) % $signed(y);
          ml = q;
          mh = r;
        end
      end
    endcase
  endfunction

  // Edges from start-sampling edge to the edge that raises done
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] m;
    int          bl;
    exp_lat = int'(W) + 1;
    m  = y;
    bl = 0;
`ifdef MDU_EARLY_EXIT_EN
    if (!o[1]) begin
      if (o == 2'b00 && y[31]) m = -y;
      for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
      exp_lat = ((bl < 1) ? 1 : bl) + 1;
    end
`else
    if (o[1] && m[0] && bl != 0) exp_lat = int'(W) + 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit now);
    if (!now) @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
  endtask

  task automatic wait_done(output int edges, output int bcyc);
    edges = 0;
    bcyc  = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) bcyc++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] y, input int edges);
    logic [31:0] mh;
    logic [31:0] ml;
    logic        mdz;
    model(o, x, y, mh, ml, mdz);
    chk({tag, "_lat"}, 64'(edges), 64'(exp_lat(o, y)));
    chk({tag, "_hi"},  64'(hi), 64'(mh));
    chk({tag, "_lo"},  64'(lo), 64'(ml));
    chk({tag, "_dz"},  64'(div_zero), 64'(mdz));
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y);
    int ed;
    int bcy;
    launch(o, x, y, 1'b0);
    wait_done(ed, bcy);
    check_result(tag, o, x, y, ed);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pulses;

    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi",   64'(hi),   64'(0));
    chk("rst_lo",   64'(lo),   64'(0));
    chk("rst_dz",   64'(div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_check("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("mult_m3x7_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_m3x7_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(e, bc);
    check_result("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    chk("multu_max_busy_cycles", 64'(bc), 64'(exp_lat(2'b01, 32'hFFFF_FFFF)));

    run_check("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    run_check("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("divu_by0", 2'b11, 32'd100, 32'd0);
    chk("divu_by0_hi_const", 64'(hi), 64'h0000_0000_0000_0064);
    run_check("multu_2x3", 2'b01, 32'd2, 32'd3);
    run_check("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
    run_check("div_m8_m3", 2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
    run_check("mulu_5x0", 2'b01, 32'd5, 32'd0);
    run_check("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = (($urandom % 8) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom % 4)
        0:       rb = 32'($urandom % 4);
        1:       rb = 32'($urandom % 1000);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      run_check($sformatf("rnd%0d", i), ro, ra, rb);
    end

    // Start during a running op is ignored
    launch(2'b01, 32'd1234, 32'd5678, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op    = 2'b00;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(e, bc);
    check_result("ignored_start", 2'b01, 32'd1234, 32'd5678, e + 5);

    // Start in the done cycle is accepted
    launch(2'b11, 32'd1000, 32'd7, 1'b0);
    wait_done(e, bc);
    check_result("b2b_first", 2'b11, 32'd1000, 32'd7, e);
    launch(2'b00, 32'hFFFF_FFF0, 32'd3, 1'b1);
    wait_done(e, bc);
    check_result("b2b_second", 2'b00, 32'hFFFF_FFF0, 32'd3, e);

    // Asynchronous reset mid-RUN
    launch(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi",   64'(hi),   64'(0));
    chk("arst_lo",   64'(lo),   64'(0));
    chk("arst_dz",   64'(div_zero), 64'(0));
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("arst_no_done", 64'(pulses), 64'(0));
    run_check("after_rst", 2'b10, 32'hFFFF_FFF9, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
